// File: rtl/display_timing_gen.sv
// Raster timing generator: counters -> renderer coordinates, sync/blank delayed to meet returned colour.
// Latency PIPE_LAT+1 pix_en ticks from counter to pins; no backpressure, pix_en_i low freezes all state.
module display_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RGB_W    = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic                                                pix_en_i,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        x_o,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        y_o,
  output logic                                                req_o,
  input  logic [RGB_W-1:0]                                    rgb_i,
  output logic [RGB_W-1:0]                                    vga_rgb_o,
  output logic                                                vga_hs_o,
  output logic                                                vga_vs_o,
  output logic                                                de_o,
  output logic                                                frame_o,
  output logic                                                line_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("display_timing_gen: every timing parameter must be >= 1");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 8) begin : g_bad_lat
      $error("display_timing_gen: PIPE_LAT must be in 0..8");
    end
  endgenerate

  typedef struct packed {
    logic req;
    logic hs;
    logic vs;
    logic frm;
    logic lin;
  } flags_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  flags_t        s0;
  flags_t        dly;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en_i) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign x_o = h_cnt;
  assign y_o = v_cnt;

  always_comb begin
    s0     = '0;
    s0.req = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0.hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    s0.vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    s0.frm = (h_cnt == '0) && (v_cnt == '0);
    s0.lin = (h_cnt == '0) && (v_cnt < V_ACT);
  end

  assign req_o = s0.req;

  // Flags ride alongside the renderer so they meet rgb_i at the output register.
  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign dly = s0;
    end else begin : g_pipe
      flags_t sr [PIPE_LAT];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
        end else if (pix_en_i) begin
          sr[0] <= s0;
          for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
        end
      end
      assign dly = sr[PIPE_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vga_rgb_o <= '0;
      de_o      <= 1'b0;
      vga_hs_o  <= ~HS_POL;
      vga_vs_o  <= ~VS_POL;
      frame_o   <= 1'b0;
      line_o    <= 1'b0;
    end else if (pix_en_i) begin
      vga_rgb_o <= dly.req ? rgb_i : '0;
      de_o      <= dly.req;
      vga_hs_o  <= dly.hs ? HS_POL : ~HS_POL;
      vga_vs_o  <= dly.vs ? VS_POL : ~VS_POL;
      frame_o   <= dly.frm;
      line_o    <= dly.lin;
    end
  end

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
Parametrised raster timing generator and video output stage. It is the common source of sync, blanking and pixel coordinates for both the VGA and the DVI display paths. It runs raster counters, issues pixel coordinates to the renderer, and delays sync/blank by a configurable renderer latency so that the returned colour aligns with them. Outputs are registered video signals: RGB, HS, VS, DE and frame/line strobes. They feed the VGA pins directly or the TMDS encoder.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level (0 = active-low)
RGB_W, 16, colour bus width
PIPE_LAT, 2, renderer latency in pixel ticks from coordinate to rgb_i (0..8)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
pix_en_i  in  1  pixel tick enable; all state advances only when high
x_o  out  $clog2(H_TOTAL)  current horizontal count (coordinate to renderer)
y_o  out  $clog2(V_TOTAL)  current vertical count
req_o  out  1  current (x_o,y_o) lies in the active area
rgb_i  in  RGB_W  renderer colour, valid PIPE_LAT ticks after its coordinate
vga_rgb_o  out  RGB_W  output colour, zero outside the active area
vga_hs_o  out  1  horizontal sync, polarity HS_POL
vga_vs_o  out  1  vertical sync, polarity VS_POL
de_o  out  1  data enable, aligned with vga_rgb_o
frame_o  out  1  high for the output tick carrying pixel (0,0)
line_o  out  1  high for output ticks carrying x=0 of an active line

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counter widths are $clog2 of the totals.
- Elaboration checks: every timing parameter must be >= 1 and PIPE_LAT must be in 0..8; otherwise elaboration stops with $error.
- Counters: h_cnt increments on each pix_en_i tick. At H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1. x_o/y_o are the counter registers directly.
- req_o (combinational from counters): asserted when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Stage-0 sync: hs_act = (H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC). vs_act is the same with the V parameters, using v_cnt (line-granular, changing at h wrap).
- Alignment: req, hs_act, vs_act and the (0,0)/x=0 flags enter a PIPE_LAT-deep shift register that advances only on pix_en_i. With PIPE_LAT=0 there is no shift; rgb_i is sampled combinationally in the same tick.
- Output register (updates on pix_en_i only; holds otherwise):
  - vga_rgb_o = delayed req ? rgb_i : 0
  - de_o = delayed req
  - vga_hs_o = delayed hs_act ? HS_POL : !HS_POL; vga_vs_o likewise with VS_POL
  - frame_o and line_o are taken from the delayed flags.
- Total latency: counter value to output pins is PIPE_LAT+1 pix_en ticks.
- frame_o/line_o are held for one pix_en tick. With pix_en_i permanently high, that is a single clk_i pulse.
- Reset values (rst_i wins over pix_en_i):
  - counters = 0
  - shift stages cleared to inactive
  - vga_rgb_o=0, de_o=0, frame_o=0, line_o=0
  - vga_hs_o=!HS_POL, vga_vs_o=!VS_POL
- Reset mid-frame: all of the above take effect on the next clk_i edge. The first post-reset tick restarts at (0,0), with no partial-sync glitch beyond that edge.
- pix_en_i low: no state changes and outputs are held. Gaps of any length are legal.

Test Plan:
Test configuration: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), PIPE_LAT=2, RGB_W=8, pix_en_i=1, rgb_i = {y[3:0],x[3:0]} delayed 2 cycles by the bench model.
- Reset: assert rst_i for 3 cycles -> all outputs at reset values (hs=vs=1, rgb=0, de=0); x_o=y_o=0 on the first cycle after release.
- Horizontal timing: release reset at cycle 0 -> x_o cycles 0..7; de_o high in cycles 3..6 with rgb 0x00..0x03; vga_hs_o low exactly in cycles 8,9 of each 8-cycle line.
- Vertical timing and strobes: vga_vs_o low for the 8 output ticks of line 4 only; frame_o pulses in cycle 3 and again 48 cycles later; line_o pulses in cycles 3, 11 and 19 only.
- Blanking mask: force rgb_i=0xFF continuously -> vga_rgb_o=0xFF only while de_o=1, otherwise 0x00.
- Clock enable: pix_en_i toggling 1,0,1,0 -> the same output sequence as the pix_en_i=1 run, each value held 2 clk_i cycles, frame period 96 cycles.
- Reset mid-frame: assert rst_i at x=2, y=1 for 1 cycle -> next cycle x_o=y_o=0, outputs at reset values; frame_o reappears 3 ticks later.
- Polarity: rerun with HS_POL=VS_POL=1 -> syncs inverted; reset value 0.
